// File: rtl/mult_share_arb_pkg.sv
// mult_share_arb_pkg: shared types and helpers for the multiplier-sharing
// arbiter.
//   state_t    : controller states IDLE -> START -> WAIT -> DONE.
//   TMO_CNT_W  : width of the WAIT-phase timeout counter. It covers
//                N + TIMEOUT_SLACK up to 255.
//   idx_w(m)   : bit width of a requester index for m requesters.
package mult_share_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int TMO_CNT_W = 8;

    function automatic int idx_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req   [M]  : request vector.
//   last  [IW] : index of the most recently served requester.
//   grant [IW] : first requester with req set, scanning last+1, last+2, ...
//                and wrapping modulo M.
//   any        : set when at least one request is present.
module rr_pick #(
    parameter int M  = 4,
    parameter int IW = 2
) (
    input  logic [M-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          any
);
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        cand  = '0;
        // The offset runs from 1 to M. The requester at 'last' is therefore
        // checked last, and it can win only when no other requester is asking.
        for (int off = 1; off <= M; off++) begin
            cand = IW'((int'(last) + off) % M);
            if (!any && req[cand]) begin
                any   = 1'b1;
                grant = cand;
            end
        end
    end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: lets M requesters share one N-cycle shift-add
// multiplier, with round-robin arbitration.
//   clock, reset_n           : rising-edge clock and async active-low reset.
//                              The multiplier uses the same reset.
//   req_valid/_multiplicand/_multiplier : per-requester request and packed
//                              operands. Slice i is [i*N +: N].
//   req_done                 : one-hot, one-cycle completion strobe.
//   result, result_owner     : last product and the requester that owns it.
//                              Both hold until the next completion.
//   busy                     : high in every state except IDLE.
//   err                      : set together with req_done when an operation
//                              times out.
//   mult_*                   : drive the multiplier's control and operand
//                              inputs.
// Optional build macro MULT_SHARE_ARB_TIMEOUT_EN enables the WAIT timeout.
// When the timeout fires, the arbiter returns result 0 with err set. When the
// macro is absent, WAIT has no time limit and err is tied to 0.
module mult_share_arbiter
    import mult_share_arb_pkg::*;
#(
    parameter int N             = 4,
    parameter int M             = 4,
    parameter int TIMEOUT_SLACK = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [M-1:0]         req_valid,
    input  logic [M*N-1:0]       req_multiplicand,
    input  logic [M*N-1:0]       req_multiplier,
    output logic [M-1:0]         req_done,
    output logic [2*N-1:0]       result,
    output logic [$clog2(M)-1:0] result_owner,
    output logic                 busy,
    output logic                 err,
    output logic                 mult_start,
    output logic [N-1:0]         mult_multiplicand,
    output logic [N-1:0]         mult_multiplier,
    input  logic [2*N-1:0]       mult_product,
    input  logic                 mult_ready
);
    localparam int IW = idx_w(M);

    // A slack of zero would abort operations that finish on schedule.
    if (M < 2 || M > 8 || TIMEOUT_SLACK < 1) begin : g_param_chk
        $error("mult_share_arbiter: M must be 2..8 and TIMEOUT_SLACK >= 1");
    end

    state_t        state, state_n;
    logic [IW-1:0] last, owner, pick;
    logic          pick_any;
    logic          timeout;
    logic [N-1:0]  sel_a, sel_b;

    rr_pick #(.M(M), .IW(IW)) u_pick (
        .req   (req_valid),
        .last  (last),
        .grant (pick),
        .any   (pick_any)
    );

    // Operand mux for the winning requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < M; i++) begin
            if (pick == IW'(i)) begin
                sel_a = req_multiplicand[i*N +: N];
                sel_b = req_multiplier[i*N +: N];
            end
        end
    end

`ifdef MULT_SHARE_ARB_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] wcnt;

    // wcnt counts the WAIT edges that have already passed without ready.
    // The timeout fires on WAIT edge number N+TIMEOUT_SLACK.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)            wcnt <= '0;
        else if (state != WAIT)  wcnt <= '0;
        else                     wcnt <= wcnt + 1'b1;
    end

    assign timeout = (state == WAIT) && !mult_ready &&
                     (wcnt == TMO_CNT_W'(N + TIMEOUT_SLACK - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err <= 1'b0;
        else          err <= timeout;
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pick_any) state_n = START;
            START:   state_n = WAIT;
            WAIT:    if (mult_ready || timeout) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath. A ready level that is left over from the previous operation
    // shows up in IDLE or START. It is ignored, because only WAIT samples it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last              <= IW'(M - 1);
            owner             <= '0;
            req_done          <= '0;
            result            <= '0;
            result_owner      <= '0;
            mult_start        <= 1'b0;
            mult_multiplicand <= '0;
            mult_multiplier   <= '0;
        end else begin
            req_done <= '0;
            case (state)
                IDLE: if (pick_any) begin
                    owner             <= pick;
                    mult_multiplicand <= sel_a;
                    mult_multiplier   <= sel_b;
                    mult_start        <= 1'b1;
                end
                START: mult_start <= 1'b0;
                WAIT: if (mult_ready || timeout) begin
                    result          <= mult_ready ? mult_product : '0;
                    result_owner    <= owner;
                    req_done[owner] <= 1'b1;
                    last            <= owner;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;
    localparam int N  = 4;
    localparam int M  = 4;
    localparam int TS = 4;
    localparam int OW = $clog2(M);

    logic           clock   = 1'b0;
    logic           reset_n = 1'b1;
    logic [M-1:0]   req_valid = '0;
    logic [N-1:0]   opa [M];
    logic [N-1:0]   opb [M];
    logic [M*N-1:0] req_multiplicand, req_multiplier;
    logic [M-1:0]   req_done;
    logic [2*N-1:0] result;
    logic [OW-1:0]  result_owner;
    logic           busy, err, mult_start, mult_ready;
    logic [N-1:0]   mult_multiplicand, mult_multiplier;
    logic [2*N-1:0] mult_product;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    always_comb begin
        req_multiplicand = '0;
        req_multiplier   = '0;
        for (int i = 0; i < M; i++) begin
            req_multiplicand[i*N +: N] = opa[i];
            req_multiplier[i*N +: N]   = opb[i];
        end
    end

    // Behavioural N-cycle multiplier. Ready rises N edges after the start edge
    // and stays high until the next start. Setting 'stuck' forces ready low.
    logic           stuck = 1'b0;
    logic           mr_q;
    logic [2*N-1:0] mp;
    logic [N-1:0]   ma, mb;
    int             mcnt;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mr_q <= 1'b0; mp <= '0; mcnt <= 0; ma <= '0; mb <= '0;
        end else if (mult_start) begin
            ma <= mult_multiplicand; mb <= mult_multiplier; mcnt <= N; mr_q <= 1'b0;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mr_q <= 1'b1;
                mp   <= {{N{1'b0}}, ma} * {{N{1'b0}}, mb};
            end
        end
    end
    assign mult_ready   = mr_q & ~stuck;
    assign mult_product = mp;

    mult_share_arbiter #(.N(N), .M(M), .TIMEOUT_SLACK(TS)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_multiplicand  (req_multiplicand),
        .req_multiplier    (req_multiplier),
        .req_done          (req_done),
        .result            (result),
        .result_owner      (result_owner),
        .busy              (busy),
        .err               (err),
        .mult_start        (mult_start),
        .mult_multiplicand (mult_multiplicand),
        .mult_multiplier   (mult_multiplier),
        .mult_product      (mult_product),
        .mult_ready        (mult_ready)
    );

    function automatic logic [2*N-1:0] mulu(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] aa, bb;
        aa = {{N{1'b0}}, a};
        bb = {{N{1'b0}}, b};
        return aa * bb;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_start(input string nm, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clock);
            if (mult_start) ok = 1'b1;
        end
        if (!ok) chk({nm, "_start_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string nm, output int cyc, output int starts, output bit ok);
        ok = 1'b0; cyc = 0; starts = 0;
        while (cyc < 64 && !ok) begin
            @(negedge clock);
            cyc++;
            if (mult_start) starts++;
            if (req_done != '0) ok = 1'b1;
        end
        if (!ok) chk({nm, "_done_timeout"}, 0, 1);
    endtask

    // One isolated request. Latency is counted in negedges from the first
    // negedge at which start is seen high.
    task automatic run_op(input string nm, input int idx, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [2*N-1:0] exp_p,
                          input int exp_lat, input bit exp_err);
        bit ok; int cyc, starts;
        logic [M-1:0] oh;
        oh = M'(1) << idx;
        opa[idx] = a; opb[idx] = b; req_valid[idx] = 1'b1;
        wait_start(nm, ok);
        if (ok) begin
            chk({nm, "_mcand"}, mult_multiplicand, a);
            chk({nm, "_mplier"}, mult_multiplier, b);
            wait_done(nm, cyc, starts, ok);
            if (ok) begin
                chk({nm, "_start_1cyc"}, starts, 0);
                chk({nm, "_latency"}, cyc, exp_lat);
                chk({nm, "_req_done"}, req_done, oh);
                chk({nm, "_result"}, result, exp_p);
                chk({nm, "_owner"}, result_owner, idx);
                chk({nm, "_err"}, err, exp_err);
            end
        end
        req_valid[idx] = 1'b0;
        @(negedge clock);
        chk({nm, "_done_clr"}, {busy, req_done}, 0);
    endtask

    typedef struct {
        int             idx;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] prod;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [6];
        int   ord [9];
        bit   ok, inflight;
        int   cyc, starts, w, own_m, last_m, ndone, r;
        logic [2*N-1:0] exp_p;
        logic [M-1:0]   oh;

        for (int i = 0; i < M; i++) begin opa[i] = '0; opb[i] = '0; end
        tbl[0] = '{1, 4'd11, 4'd6,  8'd66};
        tbl[1] = '{0, 4'd15, 4'd15, 8'd225};
        tbl[2] = '{3, 4'd0,  4'd9,  8'd0};
        tbl[3] = '{2, 4'd13, 4'd7,  8'd91};
        tbl[4] = '{1, 4'd15, 4'd1,  8'd15};
        tbl[5] = '{3, 4'd15, 4'd14, 8'd210};
        ord = '{0, 1, 2, 3, 0, 1, 2, 0, 2};

        // Reset state.
        #1 reset_n = 1'b0;
        #2 chk("rst_outputs", {busy, err, mult_start, req_done, result, result_owner,
                               mult_multiplicand, mult_multiplier}, 0);
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("idle_outputs", {busy, req_done, result, mult_start, err}, 0);
        end

        // Table-driven single operations.
        for (int t = 0; t < 6; t++)
            run_op($sformatf("tbl%0d", t), tbl[t].idx, tbl[t].a, tbl[t].b, tbl[t].prod, N + 2, 1'b0);

        // The multiplier still holds ready high, and no request is present.
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("idle_ready_ignored", {busy, mult_start, req_done}, 0);
        end

        // Round robin. All requesters stay valid and present new operands after
        // each completion. Then only requesters 0 and 2 stay valid.
        for (int i = 0; i < M; i++) begin opa[i] = N'($urandom); opb[i] = N'($urandom); end
        req_valid = '1;
        for (int k = 0; k < 9; k++) begin
            wait_start("rr", ok);
            if (!ok) break;
            wait_done("rr", cyc, starts, ok);
            if (!ok) break;
            w  = ord[k];
            oh = M'(1) << w;
            chk($sformatf("rr%0d_owner", k), result_owner, w);
            chk($sformatf("rr%0d_done", k), req_done, oh);
            chk($sformatf("rr%0d_result", k), result, mulu(opa[w], opb[w]));
            opa[w] = N'($urandom); opb[w] = N'($urandom);
            if (k == 5) req_valid = 4'b0101;
        end
        req_valid = '0;
        @(negedge clock); @(negedge clock);

        // Reset during WAIT. The outputs clear at once, and no done is issued.
        // The request is still held, so it is granted again after release.
        opa[2] = 4'd5; opb[2] = 4'd7; req_valid[2] = 1'b1;
        wait_start("midrst", ok);
        @(negedge clock); @(negedge clock);
        reset_n = 1'b0;
        #1 chk("midrst_outputs", {busy, err, mult_start, req_done, result, result_owner,
                                  mult_multiplicand, mult_multiplier}, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk("midrst_hold", {busy, mult_start, req_done}, 0);
        end
        reset_n = 1'b1;
        run_op("midrst_regrant", 2, 4'd5, 4'd7, 8'd35, N + 2, 1'b0);

`ifdef MULT_SHARE_ARB_TIMEOUT_EN
        stuck = 1'b1;
        run_op("tmo", 1, 4'd3, 4'd3, 8'd0, N + TS + 1, 1'b1);
        stuck = 1'b0;
        run_op("tmo_next", 2, 4'd6, 4'd6, 8'd36, N + 2, 1'b0);
`endif

        // Random traffic checked against the arbitration rule: the winner is the
        // first valid requester after the last one served.
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        req_valid = '0;
        last_m = M - 1; inflight = 1'b0; own_m = 0; ndone = 0; exp_p = '0;
        for (int c = 0; c < 3300; c++) begin
            @(negedge clock);
            if (mult_start) begin
                w = -1;
                for (int off = 1; off <= M; off++)
                    if (w < 0 && req_valid[(last_m + off) % M]) w = (last_m + off) % M;
                if (inflight || w < 0) chk("rnd_unexpected_grant", 1, 0);
                else begin
                    chk("rnd_grant_mcand", mult_multiplicand, opa[w]);
                    chk("rnd_grant_mplier", mult_multiplier, opb[w]);
                    inflight = 1'b1; own_m = w; exp_p = mulu(opa[w], opb[w]);
                end
            end
            if (req_done != '0) begin
                if (!inflight) chk("rnd_unexpected_done", 1, 0);
                else begin
                    oh = M'(1) << own_m;
                    chk("rnd_done", req_done, oh);
                    chk("rnd_result", result, exp_p);
                    chk("rnd_owner", result_owner, own_m);
                    chk("rnd_err", err, 0);
                    last_m = own_m; inflight = 1'b0; ndone++;
                end
            end
            for (int i = 0; i < M; i++) begin
                r = $urandom_range(15, 0);
                if (inflight && i == own_m) begin
                    // Operand changes after grant must have no effect.
                    if (r < 4) begin opa[i] = N'($urandom); opb[i] = N'($urandom); end
                end else if (c >= 3000) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    if (r < 4) begin
                        req_valid[i] = 1'b1; opa[i] = N'($urandom); opb[i] = N'($urandom);
                    end
                end else if (r == 0) begin
                    req_valid[i] = 1'b0;
                end else if (r < 3) begin
                    opa[i] = N'($urandom); opb[i] = N'($urandom);
                end
            end
        end
        chk("rnd_drained", inflight, 0);
        chk("rnd_activity", ndone > 100, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Round-robin scheduler that shares one shift-add `multiplier` instance (ports `start`/`ready`/`multiplicand`/`multiplier`/`product`, N-cycle latency) between M requesters.
- Latches the winning requester's operands, pulses `start` for one cycle, waits for `ready`, captures `product`, and returns it with a one-cycle done strobe.
- Sits directly in front of the multiplier and owns all of its control inputs.

Parameters:
N, 4, operand width in bits; must match the multiplier instance.
M, 4, number of requesters (2..8).
TIMEOUT_SLACK, 4, extra WAIT cycles beyond N before abort (used only with the optional feature).

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
req_valid  in  M  per-requester request; held with operands until matching req_done.
req_multiplicand  in  M*N  packed operands; slice i = bits [i*N +: N].
req_multiplier  in  M*N  packed operands, same packing.
req_done  out  M  one-hot, one-cycle pulse; result valid for that requester.
result  out  2N  product of the completed operation; holds until the next completion.
result_owner  out  clog2(M)  index of the requester that owns result.
busy  out  1  high in every state except IDLE.
err  out  1  high together with req_done when the operation timed out; constant 0 without the feature.
mult_start  out  1  to multiplier start.
mult_multiplicand  out  N  to multiplier.
mult_multiplier  out  N  to multiplier.
mult_product  in  2N  from multiplier.
mult_ready  in  1  from multiplier.

Behaviour:
- Reset (async, reset_n=0):
  - all outputs 0; state IDLE.
  - round-robin pointer last = M-1, so requester 0 has first priority.
  - the multiplier shares reset_n.
- States: IDLE -> START -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any req_valid is set, pick the first set index scanning last+1, last+2, ... with modulo-M wrap.
  - Latch that index as owner; latch its operands into mult_multiplicand/mult_multiplier.
  - Set mult_start=1; go to START.
- START:
  - mult_start=1 for exactly this one cycle.
  - At the next edge the multiplier loads; clear mult_start; go to WAIT.
- WAIT:
  - mult_start=0; operands held stable.
  - On an edge with mult_ready=1: result <= mult_product, result_owner <= owner, req_done[owner] <= 1, last <= owner; go to DONE.
- DONE:
  - req_done high for this cycle only; cleared at the next edge; go to IDLE.
- Latency:
  - Grant edge k; ready visible after edge k+1+N; done high from edge k+N+2 to k+N+3.
  - Next grant no earlier than edge k+N+4.
- Requester rules:
  - Requesters must drop req_valid (or present new operands) on the edge after req_done.
  - Operand changes while not granted are allowed. Operand changes after grant are ignored, because operands are latched.
  - A req_valid that drops before its grant is simply not served. There is no abort after grant.
- Simultaneous requests: strictly round-robin; no requester waits more than M-1 other operations.
- mult_ready high in IDLE or START (left over from the previous op) is ignored; only WAIT samples it.
- Arithmetic: unsigned N x N -> 2N; result is taken verbatim from mult_product.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no req_done is issued for the in-flight op.

Optional Feature:
MULT_SHARE_ARB_TIMEOUT_EN
- Defined:
  - WAIT counts cycles.
  - If mult_ready is not seen within N+TIMEOUT_SLACK cycles, go to DONE with result=0, err=1 and req_done[owner]=1.
  - last advances normally.
- Undefined: no counter; WAIT waits indefinitely; err tied 0.

Decomposition:
- Package mult_share_arb_pkg:
  - state enum (IDLE, START, WAIT, DONE);
  - function computing the index width clog2(M);
  - timeout counter width localparam.
- Sub-module rr_pick:
  - purely combinational round-robin selector (req vector + last pointer -> grant index + any);
  - reusable and unit-testable.

Test Plan:
- After reset: req_valid=0 -> busy=0, req_done=0, result=0, mult_start=0 for 10 cycles.
- Single request: req 1, multiplicand 11, multiplier 6 -> mult_start high exactly one cycle; req_done=0010 N+2 edges after grant; result=66; result_owner=1; err=0.
- Boundary operands: req 0 with 15x15 -> result=225. Then req 3 with 0x9 -> result=0.
- Round-robin: all four valid continuously, each requester re-asserting after its done -> completion order 0,1,2,3,0,1. Then only reqs 0 and 2 valid -> order alternates 2,0,2.
- Reset mid-op: reset_n low during WAIT -> all outputs 0 at once, no req_done; after release, the pending request is re-granted with the correct result.
- Timeout (macro defined): multiplier replaced by a stub with ready stuck at 0 -> req_done[owner] and err=1 on cycle N+TIMEOUT_SLACK of WAIT, result=0; the next requester is then served normally.
